// File: rtl/dds_pinc_sweeper.sv
// rtl/dds_pinc_sweeper.sv - DDS phase-increment sweep sequencer driving the config stream
// Sends start, start+step, ... then holds each word for dwell plus the DDS output latency.
module dds_pinc_sweeper #(
  parameter int PINC_WIDTH  = 16,
  parameter int DWELL_WIDTH = 32,
  parameter int LATENCY     = 7
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PINC_WIDTH-1:0]  cfg_start_pinc,
  input  logic [PINC_WIDTH-1:0]  cfg_step_pinc,
  input  logic [15:0]            cfg_num_steps,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  output logic                   m_axis_config_tvalid,
  input  logic                   m_axis_config_tready,
  output logic [PINC_WIDTH-1:0]  m_axis_config_tdata,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            step_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DWELL_WIDTH:0] LAT_EXT = (DWELL_WIDTH+1)'(LATENCY);
  localparam logic [DWELL_WIDTH:0] ONE     = (DWELL_WIDTH+1)'(1);
  localparam logic [DWELL_WIDTH:0] ZERO    = '0;

  logic [1:0]            state;
  logic [PINC_WIDTH-1:0] pinc_reg;
  logic [PINC_WIDTH-1:0] step_reg;
  logic [15:0]           num_reg;
  logic [DWELL_WIDTH:0]  dwell_n_reg;
  logic [DWELL_WIDTH:0]  dwell_cnt;
  logic                  abort_pend;

  // One extra bit keeps dwell + LATENCY from overflowing; a zero sum still dwells one cycle.
  logic [DWELL_WIDTH:0]  dwell_sum;
  logic [DWELL_WIDTH:0]  dwell_n;

  assign dwell_sum = {1'b0, cfg_dwell} + LAT_EXT;
  assign dwell_n   = (dwell_sum == ZERO) ? ONE : dwell_sum;

  assign m_axis_config_tdata = pinc_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                <= S_IDLE;
      pinc_reg             <= '0;
      step_reg             <= '0;
      num_reg              <= '0;
      dwell_n_reg          <= '0;
      dwell_cnt            <= '0;
      abort_pend           <= 1'b0;
      m_axis_config_tvalid <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      step_idx             <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            pinc_reg    <= cfg_start_pinc;
            step_reg    <= cfg_step_pinc;
            num_reg     <= cfg_num_steps;
            dwell_n_reg <= dwell_n;
            abort_pend  <= 1'b0;
            step_idx    <= '0;
            busy        <= 1'b1;
            if (cfg_num_steps == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state                <= S_SEND;
              m_axis_config_tvalid <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (m_axis_config_tready) begin
            m_axis_config_tvalid <= 1'b0;
            if (abort || abort_pend) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              abort_pend <= 1'b0;
            end else begin
              dwell_cnt <= dwell_n_reg;
              state     <= S_DWELL;
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end

        S_DWELL: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (dwell_cnt == ONE) begin
            if (step_idx == num_reg - 16'd1) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              step_idx             <= step_idx + 16'd1;
              pinc_reg             <= pinc_reg + step_reg;
              m_axis_config_tvalid <= 1'b1;
              state                <= S_SEND;
            end
          end else begin
            dwell_cnt <= dwell_cnt - ONE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
